// File: rtl/rtc_calendar_core.sv
// Binary RTC/calendar: prescaler, sec..year carry chain with Gregorian leap rule, field load/increment port.
// Optional daily alarm compiled in with RTC_ALARM_EN; without it alarm inputs are ignored and alarm_irq is 0.
module rtc_calendar_core #(
  parameter int TICK_DIV   = 32768,
  parameter int YEAR_W     = 7,
  parameter int RESET_YEAR = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [2:0]        set_sel,
  input  logic [7:0]        set_value,
  input  logic              inc_req,
  output logic              set_err,
  output logic [5:0]        sec,
  output logic [5:0]        min,
  output logic [4:0]        hour,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              sec_pulse,
  input  logic              alarm_en,
  input  logic              alarm_clr,
  output logic              alarm_irq
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

  logic [PW-1:0]     r_presc, w_nxt_presc;
  logic [5:0]        r_sec, r_min, w_nxt_sec, w_nxt_min;
  logic [4:0]        r_hour, r_day, w_nxt_hour, w_nxt_day;
  logic [3:0]        r_month, w_nxt_month;
  logic [YEAR_W-1:0] r_year, w_nxt_year;
  logic              r_err, w_nxt_err;
  logic              w_tick;
  logic [4:0]        w_dim;
  logic [5:0]        r_amin, w_nxt_amin;
  logic [4:0]        r_ahour, w_nxt_ahour;

  // Only year 100 (2100) is a non-leap multiple of 4 inside the 2000-based range.
  function automatic logic [4:0] f_dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    logic leap;
    leap = (y[1:0] == 2'b00) && (32'(y) != 32'd100);
    case (m)
      4'd2:                        f_dim = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:     f_dim = 5'd30;
      default:                     f_dim = 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] f_clamp(input logic [4:0] d, input logic [4:0] lim);
    f_clamp = (d > lim) ? lim : d;
  endfunction

  assign w_tick    = run && (r_presc == TC);
  assign set_ready = !w_tick;
  assign sec_pulse = w_tick;
  assign w_dim     = f_dim(r_month, r_year);

  always_comb begin
    w_nxt_presc = r_presc;
    w_nxt_sec   = r_sec;
    w_nxt_min   = r_min;
    w_nxt_hour  = r_hour;
    w_nxt_day   = r_day;
    w_nxt_month = r_month;
    w_nxt_year  = r_year;
    w_nxt_err   = 1'b0;
    w_nxt_amin  = r_amin;
    w_nxt_ahour = r_ahour;
    if (w_tick) begin
      w_nxt_presc = '0;
      if (r_sec != 6'd59) w_nxt_sec = r_sec + 6'd1;
      else begin
        w_nxt_sec = '0;
        if (r_min != 6'd59) w_nxt_min = r_min + 6'd1;
        else begin
          w_nxt_min = '0;
          if (r_hour != 5'd23) w_nxt_hour = r_hour + 5'd1;
          else begin
            w_nxt_hour = '0;
            if (r_day != w_dim) w_nxt_day = r_day + 5'd1;
            else begin
              w_nxt_day = 5'd1;
              if (r_month != 4'd12) w_nxt_month = r_month + 4'd1;
              else begin
                w_nxt_month = 4'd1;
                w_nxt_year  = r_year + YEAR_W'(1);
              end
            end
          end
        end
      end
    end else begin
      if (run) w_nxt_presc = r_presc + PW'(1);
      if (set_valid) begin
        case (set_sel)
          3'd0: if (set_value <= 8'd59) begin
                  w_nxt_sec   = set_value[5:0];
                  w_nxt_presc = '0;
                end else w_nxt_err = 1'b1;
          3'd1: if (set_value <= 8'd59) w_nxt_min = set_value[5:0];
                else w_nxt_err = 1'b1;
          3'd2: if (set_value <= 8'd23) w_nxt_hour = set_value[4:0];
                else w_nxt_err = 1'b1;
          3'd3: if (set_value >= 8'd1 && set_value <= {3'b000, w_dim}) w_nxt_day = set_value[4:0];
                else w_nxt_err = 1'b1;
          3'd4: if (set_value >= 8'd1 && set_value <= 8'd12) begin
                  w_nxt_month = set_value[3:0];
                  w_nxt_day   = f_clamp(r_day, f_dim(set_value[3:0], r_year));
                end else w_nxt_err = 1'b1;
          3'd5: begin
                  w_nxt_year = YEAR_W'(set_value);
                  w_nxt_day  = f_clamp(r_day, f_dim(r_month, YEAR_W'(set_value)));
                end
`ifdef RTC_ALARM_EN
          3'd6: if (set_value <= 8'd59) w_nxt_amin = set_value[5:0];
                else w_nxt_err = 1'b1;
          3'd7: if (set_value <= 8'd23) w_nxt_ahour = set_value[4:0];
                else w_nxt_err = 1'b1;
`endif
          default: ;
        endcase
      end else if (inc_req) begin
        // Increments wrap inside the field; no carry, but month/year still re-clamp the day.
        case (set_sel)
          3'd0: w_nxt_sec  = (r_sec  == 6'd59) ? 6'd0 : r_sec  + 6'd1;
          3'd1: w_nxt_min  = (r_min  == 6'd59) ? 6'd0 : r_min  + 6'd1;
          3'd2: w_nxt_hour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
          3'd3: w_nxt_day  = (r_day  >= w_dim) ? 5'd1 : r_day  + 5'd1;
          3'd4: begin
                  w_nxt_month = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
                  w_nxt_day   = f_clamp(r_day, f_dim(w_nxt_month, r_year));
                end
          3'd5: begin
                  w_nxt_year = r_year + YEAR_W'(1);
                  w_nxt_day  = f_clamp(r_day, f_dim(r_month, w_nxt_year));
                end
`ifdef RTC_ALARM_EN
          3'd6: w_nxt_amin  = (r_amin  == 6'd59) ? 6'd0 : r_amin  + 6'd1;
          3'd7: w_nxt_ahour = (r_ahour == 5'd23) ? 5'd0 : r_ahour + 5'd1;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_day   <= 5'd1;
      r_month <= 4'd1;
      r_year  <= YEAR_W'(RESET_YEAR);
      r_err   <= 1'b0;
      r_amin  <= '0;
      r_ahour <= '0;
    end else begin
      r_presc <= w_nxt_presc;
      r_sec   <= w_nxt_sec;
      r_min   <= w_nxt_min;
      r_hour  <= w_nxt_hour;
      r_day   <= w_nxt_day;
      r_month <= w_nxt_month;
      r_year  <= w_nxt_year;
      r_err   <= w_nxt_err;
      r_amin  <= w_nxt_amin;
      r_ahour <= w_nxt_ahour;
    end
  end

`ifdef RTC_ALARM_EN
  logic r_irq, w_hit;
  // Matching on the post-update time fires exactly at hh:mm:00.
  assign w_hit = w_tick && alarm_en && (w_nxt_sec == 6'd0) &&
                 (w_nxt_min == r_amin) && (w_nxt_hour == r_ahour);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_irq <= 1'b0;
    else if (w_hit)     r_irq <= 1'b1;
    else if (alarm_clr) r_irq <= 1'b0;
  end
  assign alarm_irq = r_irq;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = &{1'b0, alarm_en, alarm_clr, r_amin, r_ahour};
  assign alarm_irq = 1'b0;
`endif

  assign sec   = r_sec;
  assign min   = r_min;
  assign hour  = r_hour;
  assign day   = r_day;
  assign month = r_month;
  assign year  = r_year;
  assign set_err = r_err;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core with TICK_DIV=4; expectations queued before stimulus, checked on DUT output.
// Alarm steps follow RTC_ALARM_EN so the same bench covers both builds.
module tb_rtc_calendar_core;
  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, set_valid = 1'b0, inc_req = 1'b0;
  logic [2:0] set_sel = 3'd0;
  logic [7:0] set_value = 8'd0;
  logic       alarm_en = 1'b0, alarm_clr = 1'b0;
  logic       set_ready, set_err, sec_pulse, alarm_irq;
  logic [5:0] sec, min;
  logic [4:0] hour, day;
  logic [3:0] month;
  logic [6:0] year;

  rtc_calendar_core #(.TICK_DIV(TD), .YEAR_W(7), .RESET_YEAR(24)) dut (
    .clock(clock), .reset(reset), .run(run), .set_valid(set_valid), .set_ready(set_ready),
    .set_sel(set_sel), .set_value(set_value), .inc_req(inc_req), .set_err(set_err),
    .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
    .sec_pulse(sec_pulse), .alarm_en(alarm_en), .alarm_clr(alarm_clr), .alarm_irq(alarm_irq)
  );

  always #5 clock = ~clock;

  typedef struct { string tag; logic [63:0] val; } exp_t;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [63:0] pack(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
    return (64'(y) << 40) | (64'(mo) << 32) | (64'(d) << 24) |
           (64'(h) << 16) | (64'(mi) << 8) | 64'(s);
  endfunction

  function automatic logic [63:0] now();
    return pack(int'(year), int'(month), int'(day), int'(hour), int'(min), int'(sec));
  endfunction

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic got(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] val, input logic err_exp);
    int n;
    n = 0;
    set_valid = 1'b1; set_sel = sel; set_value = val;
    while (!set_ready && n < 8) begin step(); n++; end
    expect_val("set_err", 64'(err_exp));
    step();
    set_valid = 1'b0;
    got(64'(set_err));
  endtask

  task automatic inc(input logic [2:0] sel);
    int n;
    n = 0;
    inc_req = 1'b1; set_sel = sel;
    while (!set_ready && n < 8) begin step(); n++; end
    step();
    inc_req = 1'b0;
  endtask

  // Runs until sec_pulse is seen (bounded), takes the update edge, then freezes time again.
  task automatic pulse_then_stop(output int n, output logic [63:0] t_pulse);
    n = 0;
    run = 1'b1;
    while (!sec_pulse && n < 20) begin step(); n++; end
    t_pulse = now();
    step();
    run = 1'b0;
  endtask

  int          cnt, pulses, lows;
  logic [63:0] tp;

  initial begin
    // Reset values
    step(); step();
    expect_val("rst_time", pack(24, 1, 1, 0, 0, 0));  got(now());
    expect_val("rst_pulse", 0);                        got(64'(sec_pulse));
    expect_val("rst_err", 0);                          got(64'(set_err));
    expect_val("rst_ready", 1);                        got(64'(set_ready));
    expect_val("rst_irq", 0);                          got(64'(alarm_irq));

    // Free-running ticks: pulse on every 4th cycle, ready low only then
    reset = 1'b0; run = 1'b1;
    for (int i = 0; i < 3 * TD; i++) begin
      expect_val("tick_pulse", 64'((i % TD) == TD - 1));
      expect_val("tick_ready", 64'((i % TD) != TD - 1));
      expect_val("tick_sec", 64'(i / TD));
      got(64'(sec_pulse)); got(64'(set_ready)); got(64'(sec));
      step();
    end
    run = 1'b0;

    // New-year rollover, all fields in one edge
    wr(5, 24, 0); wr(4, 12, 0); wr(3, 31, 0); wr(2, 23, 0); wr(1, 59, 0); wr(0, 59, 0);
    expect_val("ny_latency", TD - 1);
    expect_val("ny_before", pack(24, 12, 31, 23, 59, 59));
    expect_val("ny_after", pack(25, 1, 1, 0, 0, 0));
    pulse_then_stop(cnt, tp);
    got(64'(cnt)); got(tp); got(now());

    // Leap day, then year write clamps, then out-of-range day
    wr(5, 24, 0); wr(4, 2, 0); wr(3, 28, 0); wr(2, 23, 0); wr(1, 59, 0); wr(0, 59, 0);
    expect_val("leap_feb29", pack(24, 2, 29, 0, 0, 0));
    pulse_then_stop(cnt, tp);
    got(now());
    wr(5, 25, 0);
    expect_val("year_clamp", pack(25, 2, 28, 0, 0, 0)); got(now());
    wr(3, 29, 1);
    expect_val("day29_kept", pack(25, 2, 28, 0, 0, 0)); got(now());
    step();
    expect_val("err_one_cycle", 0); got(64'(set_err));

    // Bad hour, minute increment with no carry
    wr(2, 24, 1);
    expect_val("hour24_kept", pack(25, 2, 28, 0, 0, 0)); got(now());
    wr(2, 5, 0); wr(1, 59, 0);
    inc(1);
    expect_val("inc_min_wrap", pack(25, 2, 28, 5, 0, 0)); got(now());

    // Month clamp and wrapping increments
    wr(4, 3, 0); wr(3, 31, 0); wr(4, 4, 0);
    expect_val("mar31_to_apr30", pack(25, 4, 30, 5, 0, 0)); got(now());
    inc(3);
    expect_val("inc_day_wrap", pack(25, 4, 1, 5, 0, 0)); got(now());
    wr(4, 12, 0); inc(4);
    expect_val("inc_month_wrap", pack(25, 1, 1, 5, 0, 0)); got(now());
    wr(5, 127, 0); inc(5);
    expect_val("inc_year_wrap", pack(0, 1, 1, 5, 0, 0)); got(now());

    // Write and increment together: write wins
    set_valid = 1'b1; inc_req = 1'b1; set_sel = 3'd0; set_value = 8'd10;
    step();
    set_valid = 1'b0; inc_req = 1'b0;
    expect_val("write_wins", pack(0, 1, 1, 5, 0, 10)); got(now());

    // Leave prescaler mid-count, freeze 20 cycles
    run = 1'b1; step(); step(); run = 1'b0;
    pulses = 0; lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sec_pulse) pulses++;
      if (!set_ready) lows++;
    end
    expect_val("frozen_pulses", 0); got(64'(pulses));
    expect_val("frozen_ready_low", 0); got(64'(lows));
    expect_val("frozen_time", pack(0, 1, 1, 5, 0, 10)); got(now());
    wr(0, 10, 0);
    expect_val("sec_wr_clears_presc", TD - 1);
    expect_val("after_resume", pack(0, 1, 1, 5, 0, 11));
    pulse_then_stop(cnt, tp);
    got(64'(cnt)); got(now());

    // Asynchronous reset between clock edges
    run = 1'b1;
    #2 reset = 1'b1;
    #1;
    expect_val("async_rst", pack(24, 1, 1, 0, 0, 0)); got(now());
    step();
    reset = 1'b0; run = 1'b0;

    // Daily alarm
`ifdef RTC_ALARM_EN
    wr(6, 60, 1);
`else
    wr(6, 60, 0);
`endif
    wr(7, 7, 0); wr(6, 30, 0);
    alarm_en = 1'b1;
    wr(2, 7, 0); wr(1, 29, 0); wr(0, 59, 0);
    pulse_then_stop(cnt, tp);
`ifdef RTC_ALARM_EN
    expect_val("alarm_set", 1);    got(64'(alarm_irq));
    step(); step(); step();
    expect_val("alarm_sticky", 1); got(64'(alarm_irq));
`else
    expect_val("alarm_off", 0);    got(64'(alarm_irq));
`endif
    alarm_clr = 1'b1; step(); alarm_clr = 1'b0;
    expect_val("alarm_cleared", 0); got(64'(alarm_irq));
    alarm_en = 1'b0;
    wr(2, 7, 0); wr(1, 29, 0); wr(0, 59, 0);
    pulse_then_stop(cnt, tp);
    expect_val("alarm_disabled", 0); got(64'(alarm_irq));
    expect_val("alarm_time", pack(24, 1, 1, 7, 30, 0)); got(now());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
